// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder: FSM state
// encoding, word geometry and the access-error check.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned WORD_BYTES    = 4;
    localparam int unsigned BYTE_OFS_BITS = 2;

    // An access is bad if it is not word aligned or falls beyond the array.
    function automatic logic addr_err(input logic [XLEN-1:0] addr,
                                      input int unsigned      addr_width);
        logic [XLEN-1:0] w_hi;
        w_hi = addr >> (addr_width + BYTE_OFS_BITS);
        return (addr[BYTE_OFS_BITS-1:0] != 2'd0) || (w_hi != 32'd0);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response bundle between the MEM stage (master)
// and the memory responder (slave).
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic            req_wr;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;
    logic            busy;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );

endinterface

// File: rtl/dmem_responder_array.sv
// Synchronous single-port word array with registered read (read-old on a
// simultaneous write). Contents are deliberately not reset.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [XLEN-1:0]       wdata,
    output logic [XLEN-1:0]       rdata
);

    logic [XLEN-1:0] r_mem [0:(2**ADDR_WIDTH)-1];

    // Word write and registered read on the same port.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        rdata <= r_mem[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the CPU load/store interface: accepts one word access,
// waits LATENCY cycles, then pulses a response carrying read data and error.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_wr;
    logic                  r_err;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [XLEN-1:0]       r_wdata;
    logic                  r_resp_valid;
    logic [XLEN-1:0]       r_resp_rdata;
    logic                  r_resp_err;

    logic                  w_accept;
    logic                  w_enter_resp;
    logic                  w_arr_we;
    logic [ADDR_WIDTH-1:0] w_arr_addr;
    logic [XLEN-1:0]       w_arr_rdata;

    assign bus.req_ready  = (r_state == IDLE) || (r_state == RESP);
    assign bus.busy       = (r_state == WAIT);
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;

    assign w_accept     = bus.req_valid && bus.req_ready;
    assign w_enter_resp = (r_state == WAIT) && (r_cnt == 4'd0);
    assign w_arr_we     = w_enter_resp && r_wr && !r_err;

    // The array is read at the accept edge so the word is waiting in its
    // output register by the time RESP is entered, even for LATENCY == 1.
    always_comb begin
        if (w_accept) begin
            w_arr_addr = bus.req_addr[ADDR_WIDTH+1:BYTE_OFS_BITS];
        end else begin
            w_arr_addr = r_idx;
        end
    end

    dmem_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (w_arr_we),
        .addr  (w_arr_addr),
        .wdata (r_wdata),
        .rdata (w_arr_rdata)
    );

    // Request FSM: capture on accept, count down in WAIT, respond in RESP.
    // Every access passes through WAIT, so RESP (and the response pulse)
    // lands exactly LATENCY edges after the accept edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_wr         <= 1'b0;
            r_err        <= 1'b0;
            r_idx        <= '0;
            r_wdata      <= 32'd0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                IDLE, RESP: begin
                    if (w_accept) begin
                        r_wr    <= bus.req_wr;
                        r_err   <= addr_err(bus.req_addr, ADDR_WIDTH);
                        r_idx   <= bus.req_addr[ADDR_WIDTH+1:BYTE_OFS_BITS];
                        r_wdata <= bus.req_wdata;
                        r_cnt   <= CNT_LOAD;
                        r_state <= WAIT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                WAIT: begin
                    if (w_enter_resp) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= r_err;
                        r_resp_rdata <= (!r_wr && !r_err) ? w_arr_rdata : 32'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
